stage_sequencer: RTL and testbench

Multi-cycle control sequencer for the TinyCPU core. It holds the program counter, fetches one instruction at a time over a valid-handshaked instruction port, and steps each instruction through the `STAGE_*` sequence. It drives `stage` and `current_instruction_type` into register_file_control and the memory/ALU datapath. It also resolves jumps and program termination.

---
 rtl/stage_sequencer.sv | 117 +++++++++++
 tb/tb_stage_sequencer.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/stage_sequencer.sv
// stage_sequencer: multi-cycle TinyCPU control sequencer holding the PC and stepping each fetched
// instruction through FETCH/DECODE/EXECUTE/MEMORY/REGISTER_UPDATE, with jump resolution and halt.
module stage_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        i_clk,
    input  logic        i_rst,
    output logic        o_instr_req,
    output logic [31:0] o_instr_addr,
    input  logic        i_instr_valid,
    input  logic [31:0] i_instr_data,
    output logic        o_mem_req,
    input  logic        i_mem_done,
    input  logic [31:0] i_jump_condition_data,
    input  logic [31:0] i_jump_address_data,
    output logic [2:0]  o_stage,
    output logic [31:0] o_current_instruction,
    output logic [4:0]  o_current_instruction_type,
    output logic [31:0] o_pc,
    output logic        o_halted,
    output logic        o_illegal_instr,
    output logic [31:0] o_retired_count
);
    typedef enum logic [2:0] {
        STAGE_INSTR_FETCH     = 3'd0,
        STAGE_DECODE          = 3'd1,
        STAGE_EXECUTE         = 3'd2,
        STAGE_MEMORY          = 3'd3,
        STAGE_REGISTER_UPDATE = 3'd4,
        STAGE_HALT            = 3'd5
    } stage_t;

    localparam logic [4:0] T_NO_OP = 5'd0;
    localparam logic [4:0] T_LOAD  = 5'd2;
    localparam logic [4:0] T_STORE = 5'd3;
    localparam logic [4:0] T_JUMP  = 5'd5;
    localparam logic [4:0] T_HALT  = 5'd6;

    stage_t      r_stage, w_stage_nxt;
    logic [31:0] r_pc, w_pc_nxt, r_instr, r_retired;
    logic        r_halted, r_illegal, w_retire, w_illegal, w_load_instr;
    logic [4:0]  w_type;
    logic [31:0] w_pc_inc;

    assign w_type   = r_instr[4:0];
    assign w_pc_inc = r_pc + 32'd1;

    always_comb begin
        w_stage_nxt  = r_stage;
        w_pc_nxt     = r_pc;
        w_retire     = 1'b0;
        w_illegal    = 1'b0;
        w_load_instr = 1'b0;
        case (r_stage)
            STAGE_INSTR_FETCH: begin
                w_load_instr = i_instr_valid;
                w_stage_nxt  = i_instr_valid ? STAGE_DECODE : STAGE_INSTR_FETCH;
            end
            STAGE_DECODE: begin
                w_illegal   = w_type > T_HALT;
                w_retire    = w_type == T_NO_OP;
                w_pc_nxt    = (w_type == T_NO_OP) ? w_pc_inc : r_pc;
                w_stage_nxt = (w_type >= T_HALT) ? STAGE_HALT :
                              (w_type == T_NO_OP) ? STAGE_INSTR_FETCH : STAGE_EXECUTE;
            end
            STAGE_EXECUTE: begin
                w_retire    = w_type == T_JUMP;
                w_pc_nxt    = (w_type != T_JUMP) ? r_pc :
                              (i_jump_condition_data != 32'd0) ? i_jump_address_data : w_pc_inc;
                w_stage_nxt = (w_type == T_LOAD || w_type == T_STORE) ? STAGE_MEMORY :
                              (w_type == T_JUMP) ? STAGE_INSTR_FETCH : STAGE_REGISTER_UPDATE;
            end
            STAGE_MEMORY: begin
                w_retire    = i_mem_done && w_type == T_STORE;
                w_pc_nxt    = w_retire ? w_pc_inc : r_pc;
                w_stage_nxt = !i_mem_done ? STAGE_MEMORY :
                              (w_type == T_LOAD) ? STAGE_REGISTER_UPDATE : STAGE_INSTR_FETCH;
            end
            STAGE_REGISTER_UPDATE: begin
                w_retire    = 1'b1;
                w_pc_nxt    = w_pc_inc;
                w_stage_nxt = STAGE_INSTR_FETCH;
            end
            STAGE_HALT: w_stage_nxt = STAGE_HALT;
            default:    w_stage_nxt = STAGE_INSTR_FETCH;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_stage   <= STAGE_INSTR_FETCH;
            r_pc      <= RESET_PC;
            r_instr   <= 32'd0;
            r_retired <= 32'd0;
            r_halted  <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            r_stage   <= w_stage_nxt;
            r_pc      <= w_pc_nxt;
            r_instr   <= w_load_instr ? i_instr_data : r_instr;
            r_retired <= w_retire ? r_retired + 32'd1 : r_retired;
            r_halted  <= r_halted | (w_stage_nxt == STAGE_HALT);
            r_illegal <= r_illegal | w_illegal;
        end
    end

    assign o_instr_req                = (r_stage == STAGE_INSTR_FETCH) && !i_rst;
    assign o_instr_addr               = r_pc;
    assign o_mem_req                  = r_stage == STAGE_MEMORY;
    assign o_stage                    = r_stage;
    assign o_current_instruction      = r_instr;
    assign o_current_instruction_type = w_type;
    assign o_pc                       = r_pc;
    assign o_halted                   = r_halted;
    assign o_illegal_instr            = r_illegal;
    assign o_retired_count            = r_retired;
endmodule

// File: tb/tb_stage_sequencer.sv
// tb_stage_sequencer: directed checks of stage sequencing, PC/jump handling, halt and reset behaviour.
module tb_stage_sequencer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        instr_req, instr_valid = 1'b0, mem_req, mem_done = 1'b0, halted, illegal;
    logic [31:0] instr_addr, instr_data = 32'd0, jcond = 32'd0, jaddr = 32'd0;
    logic [31:0] cur_instr, pc, retired;
    logic [2:0]  stage;
    logic [4:0]  cur_type;
    int n_cmp = 0;
    int n_fail = 0;

    stage_sequencer #(.RESET_PC(32'h10)) dut (
        .i_clk(clk), .i_rst(rst),
        .o_instr_req(instr_req), .o_instr_addr(instr_addr),
        .i_instr_valid(instr_valid), .i_instr_data(instr_data),
        .o_mem_req(mem_req), .i_mem_done(mem_done),
        .i_jump_condition_data(jcond), .i_jump_address_data(jaddr),
        .o_stage(stage), .o_current_instruction(cur_instr),
        .o_current_instruction_type(cur_type), .o_pc(pc),
        .o_halted(halted), .o_illegal_instr(illegal), .o_retired_count(retired)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
    endtask

    task automatic fetch(input logic [31:0] d);
        instr_valid = 1'b1;
        instr_data  = d;
        step();
        instr_valid = 1'b0;
    endtask

    task automatic test_reset();
        step();
        step();
        n_cmp++; if (stage !== 3'd0) begin n_fail++; $display("FAIL rst_stage got %0d want 0", stage); end
        n_cmp++; if (pc !== 32'h10) begin n_fail++; $display("FAIL rst_pc got %h want 10", pc); end
        n_cmp++; if (instr_req !== 1'b0) begin n_fail++; $display("FAIL rst_instr_req got %b want 0", instr_req); end
        n_cmp++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL rst_mem_req got %b want 0", mem_req); end
        n_cmp++; if ({halted, illegal} !== 2'b00) begin n_fail++; $display("FAIL rst_flags got %b want 00", {halted, illegal}); end
        n_cmp++; if (retired !== 32'd0) begin n_fail++; $display("FAIL rst_retired got %0d want 0", retired); end
        n_cmp++; if (cur_instr !== 32'd0) begin n_fail++; $display("FAIL rst_instr got %h want 0", cur_instr); end
        rst = 1'b0;
        #1;
        n_cmp++; if (instr_req !== 1'b1) begin n_fail++; $display("FAIL first_req got %b want 1", instr_req); end
        n_cmp++; if (instr_addr !== 32'h10) begin n_fail++; $display("FAIL first_addr got %h want 10", instr_addr); end
    endtask

    task automatic test_alu();
        logic [2:0] exp_seq [4] = '{3'd1, 3'd2, 3'd4, 3'd0};
        fetch(32'h4);
        n_cmp++; if (cur_type !== 5'd4) begin n_fail++; $display("FAIL alu_type got %0d want 4", cur_type); end
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (stage !== exp_seq[i]) begin n_fail++; $display("FAIL alu_seq[%0d] got %0d want %0d", i, stage, exp_seq[i]); end
            if (i < 3) step();
        end
        n_cmp++; if (pc !== 32'h11) begin n_fail++; $display("FAIL alu_pc got %h want 11", pc); end
        n_cmp++; if (retired !== 32'd1) begin n_fail++; $display("FAIL alu_retired got %0d want 1", retired); end
    endtask

    task automatic test_load();
        int req_cycles = 0;
        fetch(32'h2);
        n_cmp++; if (stage !== 3'd1) begin n_fail++; $display("FAIL load_decode got %0d want 1", stage); end
        step();
        n_cmp++; if (stage !== 3'd2) begin n_fail++; $display("FAIL load_exec got %0d want 2", stage); end
        step();
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (stage !== 3'd3) begin n_fail++; $display("FAIL load_mem[%0d] got %0d want 3", i, stage); end
            if (mem_req) req_cycles++;
            if (i == 2) mem_done = 1'b1;
            step();
        end
        mem_done = 1'b0;
        n_cmp++; if (req_cycles != 3 || mem_req !== 1'b0) begin n_fail++; $display("FAIL load_mem_req got %0d cycles (now %b) want 3 (now 0)", req_cycles, mem_req); end
        n_cmp++; if (stage !== 3'd4) begin n_fail++; $display("FAIL load_regupd got %0d want 4", stage); end
        n_cmp++; if (pc !== 32'h11) begin n_fail++; $display("FAIL load_pc_hold got %h want 11", pc); end
        step();
        n_cmp++; if (stage !== 3'd0) begin n_fail++; $display("FAIL load_fetch got %0d want 0", stage); end
        n_cmp++; if (pc !== 32'h12 || retired !== 32'd2) begin n_fail++; $display("FAIL load_pc_ret got %h/%0d want 12/2", pc, retired); end
    endtask

    task automatic test_store();
        fetch(32'h3);
        step();
        step();
        mem_done = 1'b1;
        n_cmp++; if (stage !== 3'd3 || mem_req !== 1'b1) begin n_fail++; $display("FAIL store_mem got %0d/%b want 3/1", stage, mem_req); end
        step();
        mem_done = 1'b0;
        n_cmp++; if (stage !== 3'd0 || pc !== 32'h13 || retired !== 32'd3) begin n_fail++; $display("FAIL store_done got %0d/%h/%0d want 0/13/3", stage, pc, retired); end
    endtask

    task automatic do_jump(input logic [31:0] c, input logic [31:0] a);
        fetch(32'h5);
        jcond = c;
        jaddr = a;
        step();
        step();
        jcond = 32'd0;
        jaddr = 32'd0;
    endtask

    task automatic test_jump();
        do_jump(32'd1, 32'h40);
        n_cmp++; if (stage !== 3'd0 || instr_addr !== 32'h40) begin n_fail++; $display("FAIL jump_taken got %0d/%h want 0/40", stage, instr_addr); end
        n_cmp++; if (retired !== 32'd4) begin n_fail++; $display("FAIL jump_taken_ret got %0d want 4", retired); end
        do_jump(32'd0, 32'h80);
        n_cmp++; if (instr_addr !== 32'h41) begin n_fail++; $display("FAIL jump_not_taken got %h want 41", instr_addr); end
        n_cmp++; if (retired !== 32'd5) begin n_fail++; $display("FAIL jump_not_taken_ret got %0d want 5", retired); end
    endtask

    task automatic test_nop_wrap();
        do_jump(32'h8000_0000, 32'hFFFF_FFFF);
        n_cmp++; if (pc !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL wrap_setup got %h want ffffffff", pc); end
        fetch(32'h0);
        n_cmp++; if (stage !== 3'd1) begin n_fail++; $display("FAIL nop_decode got %0d want 1", stage); end
        step();
        n_cmp++; if (stage !== 3'd0 || pc !== 32'd0 || retired !== 32'd7) begin n_fail++; $display("FAIL nop_wrap got %0d/%h/%0d want 0/0/7", stage, pc, retired); end
    endtask

    task automatic test_halt();
        int bad = 0;
        do_jump(32'd1, 32'h5);
        fetch(32'h6);
        step();
        n_cmp++; if (stage !== 3'd5 || halted !== 1'b1 || illegal !== 1'b0) begin n_fail++; $display("FAIL halt_state got %0d/%b/%b want 5/1/0", stage, halted, illegal); end
        n_cmp++; if (pc !== 32'h5 || retired !== 32'd8) begin n_fail++; $display("FAIL halt_pc_ret got %h/%0d want 5/8", pc, retired); end
        instr_valid = 1'b1;
        mem_done = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (instr_req !== 1'b0 || mem_req !== 1'b0 || stage !== 3'd5) bad++;
            step();
        end
        instr_valid = 1'b0;
        mem_done = 1'b0;
        n_cmp++; if (bad != 0) begin n_fail++; $display("FAIL halt_absorb got %0d bad cycles want 0", bad); end
    endtask

    task automatic test_illegal();
        rst = 1'b1;
        #1;
        n_cmp++; if (stage !== 3'd0 || halted !== 1'b0) begin n_fail++; $display("FAIL async_rst got %0d/%b want 0/0", stage, halted); end
        step();
        rst = 1'b0;
        fetch(32'h1F);
        step();
        n_cmp++; if (stage !== 3'd5 || halted !== 1'b1 || illegal !== 1'b1) begin n_fail++; $display("FAIL illegal_halt got %0d/%b/%b want 5/1/1", stage, halted, illegal); end
        n_cmp++; if (retired !== 32'd0) begin n_fail++; $display("FAIL illegal_ret got %0d want 0", retired); end
        rst = 1'b1;
        #1;
        n_cmp++; if (stage !== 3'd0 || pc !== 32'h10 || halted !== 1'b0 || illegal !== 1'b0 || instr_req !== 1'b0) begin n_fail++; $display("FAIL illegal_rst got %0d/%h/%b/%b/%b want 0/10/0/0/0", stage, pc, halted, illegal, instr_req); end
        step();
        rst = 1'b0;
        #1;
        n_cmp++; if (instr_req !== 1'b1 || instr_addr !== 32'h10) begin n_fail++; $display("FAIL illegal_refetch got %b/%h want 1/10", instr_req, instr_addr); end
    endtask

    task automatic test_rst_mid_memory();
        step();
        fetch(32'h2);
        step();
        step();
        n_cmp++; if (stage !== 3'd3 || mem_req !== 1'b1) begin n_fail++; $display("FAIL midmem_enter got %0d/%b want 3/1", stage, mem_req); end
        rst = 1'b1;
        #1;
        n_cmp++; if (stage !== 3'd0 || mem_req !== 1'b0) begin n_fail++; $display("FAIL midmem_rst got %0d/%b want 0/0", stage, mem_req); end
        step();
        rst = 1'b0;
        mem_done = 1'b1;
        step();
        mem_done = 1'b0;
        step();
        n_cmp++; if (stage !== 3'd0 || mem_req !== 1'b0 || pc !== 32'h10) begin n_fail++; $display("FAIL midmem_done_ignored got %0d/%b/%h want 0/0/10", stage, mem_req, pc); end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load();
        test_store();
        test_jump();
        test_nop_wrap();
        test_halt();
        test_illegal();
        test_rst_mid_memory();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
